// File: rtl/cnn_ctrl_pkg.sv
// Shared types and instruction field helpers for the CNN layer sequencer.
// Opcode/state encodings and instruction field positions live here.
package cnn_ctrl_pkg;

  localparam int OPCODE_WIDTH = 4;
  localparam logic [OPCODE_WIDTH-1:0] HALT_OPCODE = 4'hF;

  typedef enum logic [OPCODE_WIDTH-1:0] {
    OP_FULLY_CONVOL = 4'h0,
    OP_POOLING      = 4'h1,
    OP_HALT         = HALT_OPCODE
  } opcode_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_START  = 3'd2,
    ST_RUN    = 3'd3,
    ST_DONE   = 3'd4,
    ST_HALTED = 3'd5
  } state_e;

  // The opcode occupies the top nibble; the write count sits directly below it.
  function automatic int opcode_msb(input int instr_width);
    return instr_width - 1;
  endfunction

  function automatic int count_msb(input int instr_width);
    return instr_width - 1 - OPCODE_WIDTH;
  endfunction

endpackage

// File: rtl/layer_sequencer_write_counter.sv
// Loadable down-counter of remaining engine writes for the active layer.
// last flags the final outstanding write so the sequencer exits before wrapping.
module write_counter #(
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load,
  input  logic [COUNT_WIDTH-1:0] load_value,
  input  logic                   dec,
  output logic                   last
);

  logic [COUNT_WIDTH-1:0] remaining;

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      remaining <= '0;
    end else if (load) begin
      remaining <= load_value;
    end else if (dec && (remaining != '0)) begin
      remaining <= remaining - COUNT_WIDTH'(1);
    end
  end

  assign last = (remaining == COUNT_WIDTH'(1));

endmodule

// File: rtl/layer_sequencer.sv
// Layer sequencer: fetches instructions, starts the selected engine and counts its writes.
// Optional macro PERF_COUNTER_EN adds the layer_cycles RUN-duration output.
module layer_sequencer
  import cnn_ctrl_pkg::*;
#(
  parameter int INSTRUCTION_WIDTH = 32,
  parameter int NUM_ENGINES       = 3,
  parameter int COUNT_WIDTH       = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [INSTRUCTION_WIDTH-1:0] instr_data,
  input  logic                         instr_valid,
  output logic                         instr_ready,
  input  logic [NUM_ENGINES-1:0]       ready_write,
  output logic [NUM_ENGINES-1:0]       engine_sel,
  output logic                         engine_start,
  output logic                         write_signal,
  output logic                         layer_done,
  output logic                         busy,
  output logic                         halted,
  output logic                         illegal_op
`ifdef PERF_COUNTER_EN
  ,
  output logic [31:0]                  layer_cycles
`endif
);

  localparam int OP_MSB  = opcode_msb(INSTRUCTION_WIDTH);
  localparam int CNT_MSB = count_msb(INSTRUCTION_WIDTH);

  localparam logic [2:0] S_IDLE   = ST_IDLE;
  localparam logic [2:0] S_FETCH  = ST_FETCH;
  localparam logic [2:0] S_START  = ST_START;
  localparam logic [2:0] S_RUN    = ST_RUN;
  localparam logic [2:0] S_DONE   = ST_DONE;
  localparam logic [2:0] S_HALTED = ST_HALTED;

  logic [2:0]              state;
  logic [2:0]              state_nxt;
  logic [OPCODE_WIDTH-1:0] opcode;
  logic [COUNT_WIDTH-1:0]  count;
  logic [OPCODE_WIDTH-1:0] engine_idx;
  logic                    accept;
  logic                    is_halt;
  logic                    is_engine_op;
  logic                    cnt_load;
  logic                    cnt_last;

  assign opcode       = instr_data[OP_MSB -: OPCODE_WIDTH];
  assign count        = instr_data[CNT_MSB -: COUNT_WIDTH];
  assign accept       = (state == S_FETCH) && instr_valid;
  assign is_halt      = (opcode == OP_HALT);
  assign is_engine_op = (opcode < OPCODE_WIDTH'(NUM_ENGINES));
  assign cnt_load     = accept && is_engine_op && (count != '0);

  always_comb begin
    // NOTE: defaulting every combinationally assigned signal first keeps all
    // paths assigned, so no latch can be inferred.
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_FETCH;
      end
      S_FETCH: begin
        if (instr_valid) begin
          if (is_halt)           state_nxt = S_HALTED;
          else if (!is_engine_op) state_nxt = S_HALTED;
          else if (count == '0)  state_nxt = S_DONE;
          else                   state_nxt = S_START;
        end
      end
      S_START:  state_nxt = S_RUN;
      S_RUN: begin
        if (write_signal && cnt_last) state_nxt = S_DONE;
      end
      S_DONE:   state_nxt = S_FETCH;
      S_HALTED: begin
        if (start) state_nxt = S_FETCH;
      end
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      engine_idx <= '0;
      illegal_op <= 1'b0;
    end else begin
      state <= state_nxt;
      if (cnt_load) engine_idx <= opcode;
      if (accept && !is_halt && !is_engine_op) begin
        illegal_op <= 1'b1;
      end else if ((state == S_HALTED) && start) begin
        illegal_op <= 1'b0;
      end
    end
  end

  // Selection is decoded from the latched index so it stays stable from START through RUN.
  always_comb begin
    engine_sel = '0;
    if ((state == S_START) || (state == S_RUN)) begin
      engine_sel = NUM_ENGINES'(1) << engine_idx;
    end
  end

  assign write_signal = (state == S_RUN) && (|(ready_write & engine_sel));
  assign instr_ready  = (state == S_FETCH);
  assign engine_start = (state == S_START);
  assign layer_done   = (state == S_DONE);
  assign halted       = (state == S_HALTED);
  assign busy         = (state == S_FETCH) || (state == S_START) ||
                        (state == S_RUN)   || (state == S_DONE);

  write_counter #(
    .COUNT_WIDTH(COUNT_WIDTH)
  ) u_write_counter (
    .clk       (clk),
    .rst       (rst),
    .load      (cnt_load),
    .load_value(count),
    .dec       (write_signal),
    .last      (cnt_last)
  );

`ifdef PERF_COUNTER_EN
  logic [31:0] cycle_cnt;

  // Clearing in FETCH as well makes a zero-count layer report 0 cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_cnt    <= '0;
      layer_cycles <= '0;
    end else begin
      if ((state == S_FETCH) || (state == S_START)) begin
        cycle_cnt <= '0;
      end else if ((state == S_RUN) && (cycle_cnt != '1)) begin
        cycle_cnt <= cycle_cnt + 32'd1;
      end
      if (state == S_DONE) layer_cycles <= cycle_cnt;
    end
  end
`endif

endmodule

// File: tb/tb_layer_sequencer.sv
// Self-checking bench for layer_sequencer: directed table, hand sequences and randomized layers.
// Build with PERF_COUNTER_EN defined to also exercise the layer_cycles output.
module tb_layer_sequencer;

  localparam int IW = 32;
  localparam int NE = 3;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [IW-1:0] instr_data;
  logic          instr_valid;
  logic          instr_ready;
  logic [NE-1:0] ready_write;
  logic [NE-1:0] engine_sel;
  logic          engine_start;
  logic          write_signal;
  logic          layer_done;
  logic          busy;
  logic          halted;
  logic          illegal_op;
`ifdef PERF_COUNTER_EN
  logic [31:0]   layer_cycles;
`endif

  int    checks = 0;
  int    errors = 0;
  string cur_tag = "init";

  always #5 clk = ~clk;

  layer_sequencer #(
    .INSTRUCTION_WIDTH(IW),
    .NUM_ENGINES      (NE),
    .COUNT_WIDTH      (CW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .instr_data  (instr_data),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .ready_write (ready_write),
    .engine_sel  (engine_sel),
    .engine_start(engine_start),
    .write_signal(write_signal),
    .layer_done  (layer_done),
    .busy        (busy),
    .halted      (halted),
    .illegal_op  (illegal_op)
`ifdef PERF_COUNTER_EN
    ,
    .layer_cycles(layer_cycles)
`endif
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s/%s actual=%0h expected=%0h", cur_tag, name, act, exp);
    end
  endtask

  // kind: 0 = engine layer, 1 = HALT, 2 = illegal opcode
  typedef struct {
    logic [IW-1:0] instr;
    logic [NE-1:0] exp_sel;
    int            exp_writes;
    int            exp_kind;
    int            mode;
  } vec_t;

  function automatic logic [IW-1:0] mk(input logic [3:0] op, input logic [15:0] cnt,
                                       input logic [11:0] rsv);
    return {op, cnt, rsv};
  endfunction

  // Reference decode straight from the instruction format and opcode map.
  function automatic vec_t predict(input logic [IW-1:0] w, input int mode);
    vec_t v;
    int   op;
    op           = int'(w[IW-1 -: 4]);
    v.instr      = w;
    v.mode       = mode;
    v.exp_sel    = '0;
    v.exp_writes = 0;
    if (op == 15) begin
      v.exp_kind = 1;
    end else if (op < NE) begin
      v.exp_kind   = 0;
      v.exp_sel    = NE'(1 << op);
      v.exp_writes = int'(w[IW-5 -: CW]);
    end else begin
      v.exp_kind = 2;
    end
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Entered and left at posedge+1 with the sequencer in FETCH.
  task automatic run_instr(input vec_t v);
    int            remaining;
    int            cyc;
    logic          wr_exp;
    logic [NE-1:0] rw;
    instr_data  = v.instr;
    instr_valid = 1'b1;
    @(negedge clk);
    check("instr_ready", instr_ready, 1);
    check("busy_fetch", busy, 1);
    tick();
    instr_valid = 1'b0;
    instr_data  = $urandom;
    if (v.exp_kind != 0) begin
      ready_write = '1;
      @(negedge clk);
      check("halted", halted, 1);
      check("busy_halted", busy, 0);
      check("instr_ready_halted", instr_ready, 0);
      check("illegal_op", illegal_op, (v.exp_kind == 2) ? 1 : 0);
      check("sel_halted", engine_sel, 0);
      check("write_halted", write_signal, 0);
      tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      check("halted_clear", halted, 0);
      check("illegal_clear", illegal_op, 0);
      check("instr_ready_resume", instr_ready, 1);
      return;
    end
    if (v.exp_writes == 0) begin
      ready_write = '1;
      @(negedge clk);
      check("done_zero", layer_done, 1);
      check("no_start_zero", engine_start, 0);
      check("sel_zero", engine_sel, 0);
      check("write_zero", write_signal, 0);
      tick();
      return;
    end
    ready_write = '1;
    @(negedge clk);
    check("engine_start", engine_start, 1);
    check("sel_start", engine_sel, v.exp_sel);
    check("write_in_start", write_signal, 0);
    check("done_in_start", layer_done, 0);
    tick();
    remaining = v.exp_writes;
    cyc       = 0;
    while ((remaining > 0) && (cyc < 300)) begin
      rw = NE'($urandom);
      if (v.mode == 1) rw = (cyc % 2 == 0) ? (rw | v.exp_sel) : (rw & ~v.exp_sel);
      ready_write = rw;
      start       = 1'($urandom);
      @(negedge clk);
      wr_exp = |(rw & v.exp_sel);
      check("write_signal", write_signal, wr_exp);
      check("sel_run", engine_sel, v.exp_sel);
      check("start_run", engine_start, 0);
      check("done_run", layer_done, 0);
      if (wr_exp) remaining--;
      cyc++;
      tick();
    end
    check("write_timeout", remaining, 0);
    start       = 1'b0;
    ready_write = '1;
    @(negedge clk);
    check("layer_done", layer_done, 1);
    check("sel_done", engine_sel, 0);
    check("write_done", write_signal, 0);
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vecs[9];
    vec_t v;

    rst         = 1'b1;
    start       = 1'b0;
    instr_valid = 1'b0;
    instr_data  = '0;
    ready_write = '1;

    cur_tag = "reset";
    @(negedge clk);
    check("instr_ready", instr_ready, 0);
    check("engine_sel", engine_sel, 0);
    check("engine_start", engine_start, 0);
    check("write_signal", write_signal, 0);
    check("layer_done", layer_done, 0);
    check("busy", busy, 0);
    check("halted", halted, 0);
    check("illegal_op", illegal_op, 0);
`ifdef PERF_COUNTER_EN
    check("layer_cycles", layer_cycles, 0);
`endif
    tick();
    rst         = 1'b0;
    instr_valid = 1'b1;
    tick();
    check("idle_ready", instr_ready, 0);
    check("idle_busy", busy, 0);
    instr_valid = 1'b0;
    start       = 1'b1;
    tick();
    start = 1'b0;
    check("fetch_ready", instr_ready, 1);

    vecs[0] = '{instr: mk(4'h0, 16'd3, 12'h000), exp_sel: 3'b001, exp_writes: 3, exp_kind: 0, mode: 1};
    vecs[1] = '{instr: mk(4'h1, 16'd2, 12'hABC), exp_sel: 3'b010, exp_writes: 2, exp_kind: 0, mode: 0};
    vecs[2] = '{instr: mk(4'h0, 16'd0, 12'h000), exp_sel: 3'b000, exp_writes: 0, exp_kind: 0, mode: 0};
    vecs[3] = '{instr: mk(4'h2, 16'd1, 12'h000), exp_sel: 3'b100, exp_writes: 1, exp_kind: 0, mode: 0};
    vecs[4] = '{instr: mk(4'h7, 16'd5, 12'h000), exp_sel: 3'b000, exp_writes: 0, exp_kind: 2, mode: 0};
    vecs[5] = '{instr: mk(4'h1, 16'd4, 12'h5A5), exp_sel: 3'b010, exp_writes: 4, exp_kind: 0, mode: 1};
    vecs[6] = '{instr: 32'hFFFF_FFFF,           exp_sel: 3'b000, exp_writes: 0, exp_kind: 1, mode: 0};
    vecs[7] = '{instr: mk(4'h3, 16'd2, 12'h000), exp_sel: 3'b000, exp_writes: 0, exp_kind: 2, mode: 0};
    vecs[8] = '{instr: mk(4'h2, 16'd5, 12'hFFF), exp_sel: 3'b100, exp_writes: 5, exp_kind: 0, mode: 1};
    for (int i = 0; i < 9; i++) begin
      cur_tag = $sformatf("vec%0d", i);
      run_instr(vecs[i]);
    end

`ifdef PERF_COUNTER_EN
    cur_tag = "perf";
    run_instr(predict(mk(4'h0, 16'd4, 12'h000), 1));
    check("layer_cycles_4", layer_cycles, 7);
    run_instr(predict(mk(4'h1, 16'd0, 12'h000), 0));
    check("layer_cycles_0", layer_cycles, 0);
`endif

    // Reset in the middle of a layer with five writes still outstanding.
    cur_tag     = "mid_reset";
    instr_data  = mk(4'h2, 16'd8, 12'h000);
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    tick();
    ready_write = 3'b100;
    for (int i = 0; i < 3; i++) tick();
    ready_write = '1;
    check("write_before_rst", write_signal, 1);
    #2;
    rst = 1'b1;
    #1;
    check("sel_async", engine_sel, 0);
    check("write_async", write_signal, 0);
    check("busy_async", busy, 0);
    check("ready_async", instr_ready, 0);
    tick();
    rst         = 1'b0;
    ready_write = '0;
    check("idle_after_rst", busy, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    run_instr(predict(mk(4'h0, 16'd1, 12'h000), 0));

    for (int i = 0; i < 40; i++) begin
      int            r;
      logic [3:0]    op;
      logic [IW-1:0] w;
      cur_tag = $sformatf("rand%0d", i);
      r = $urandom_range(0, 9);
      if (r < 8)       op = 4'(r % NE);
      else if (r == 8) op = 4'($urandom_range(NE, 14));
      else             op = 4'hF;
      w = mk(op, 16'($urandom_range(0, 6)), 12'($urandom));
      v = predict(w, int'($urandom_range(0, 1)));
      run_instr(v);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
